switch_debounce_bank: RTL and testbench

SWITCH_DEBOUNCE_BANK -- requirements
Module: switch_debounce_bank

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_channel.sv | 80 ++++++++
 rtl/switch_debounce_bank.sv | 36 +++
 tb/tb_switch_debounce_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared defaults and helpers for the switch debounce bank.
// Edge-pulse outputs are built only when DEBOUNCE_EDGE_EN is defined.
package debounce_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_LIMIT = 250000;
  localparam int unsigned DEFAULT_NUM_SW         = 4;

  // Per-cycle decision taken by a channel's stability counter.
  typedef enum logic [1:0] {
    CNT_CLEAR = 2'd0,
    CNT_STEP  = 2'd1,
    CNT_FLIP  = 2'd2
  } cnt_action_e;

  // Counter holds 0..limit-1, so clog2(limit) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch: 2-flop synchronizer, stability counter, stable level.
// Rise/fall pulse flops exist only when DEBOUNCE_EDGE_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic sw_o
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic rise_o,
  output logic fall_o
`endif
);

  localparam int unsigned    CW      = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

  logic [1:0]    sync_q;
  logic          s;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;
  cnt_action_e   act;

  assign s = sync_q[1];

  // Any sample equal to the stable level restarts the count, so glitches never accumulate.
  always_comb begin
    act     = CNT_CLEAR;
    cnt_d   = '0;
    state_d = state_q;
    if (s != state_q) begin
      act = (cnt_q == CNT_MAX) ? CNT_FLIP : CNT_STEP;
    end
    case (act)
      CNT_STEP: cnt_d = cnt_q + CW'(1);
      CNT_FLIP: begin
        cnt_d   = '0;
        state_d = ~state_q;
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], sw_i};
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign sw_o = state_q;

`ifdef DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Pulses are decoded from the flip decision so they land with the state change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= (act == CNT_FLIP) && !state_q;
      fall_q <= (act == CNT_FLIP) &&  state_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/switch_debounce_bank.sv
// Bank of NUM_SW independent switch debouncers.
// Define DEBOUNCE_EDGE_EN to add the o_Rise/o_Fall pulse ports.
module switch_debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int unsigned NUM_SW         = DEFAULT_NUM_SW
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [NUM_SW-1:0] i_Switch,
  output logic [NUM_SW-1:0] o_Switch
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic [NUM_SW-1:0] o_Rise,
  output logic [NUM_SW-1:0] o_Fall
`endif
);

  for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
    ) u_ch (
      .clk_i (i_Clk),
      .rst_i (i_Rst),
      .sw_i  (i_Switch[g]),
      .sw_o  (o_Switch[g])
`ifdef DEBOUNCE_EDGE_EN
      ,
      .rise_o(o_Rise[g]),
      .fall_o(o_Fall[g])
`endif
    );
  end

endmodule

// File: tb/tb_switch_debounce_bank.sv
// Scoreboard bench for switch_debounce_bank with DEBOUNCE_LIMIT=4, NUM_SW=4.
// Works with or without DEBOUNCE_EDGE_EN defined.
module tb_switch_debounce_bank;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned NSW   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NSW-1:0] sw  = '0;
  logic [NSW-1:0] osw, orise, ofall;

  always #5 clk = ~clk;

  switch_debounce_bank #(
    .DEBOUNCE_LIMIT(LIMIT),
    .NUM_SW        (NSW)
  ) dut (
    .i_Clk   (clk),
    .i_Rst   (rst),
    .i_Switch(sw),
    .o_Switch(osw)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .o_Rise  (orise),
    .o_Fall  (ofall)
`endif
  );

`ifndef DEBOUNCE_EDGE_EN
  assign orise = '0;
  assign ofall = '0;
`endif

  typedef struct {
    int unsigned    cyc;
    logic [NSW-1:0] sw;
    logic [NSW-1:0] rise;
    logic [NSW-1:0] fall;
  } exp_t;

  exp_t evq[$];
  exp_t snapq[$];

  int unsigned cyc    = 0;
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  logic [3*NSW-1:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected output-change events; with edge pulses enabled the pulse end is an event too.
  task automatic expect_evt(input int unsigned c, input logic [NSW-1:0] s,
                            input logic [NSW-1:0] r, input logic [NSW-1:0] f);
`ifdef DEBOUNCE_EDGE_EN
    evq.push_back('{cyc: c, sw: s, rise: r, fall: f});
    if ((r | f) != '0) evq.push_back('{cyc: c + 1, sw: s, rise: '0, fall: '0});
`else
    evq.push_back('{cyc: c, sw: s, rise: '0, fall: '0});
    if (r === f) begin end
`endif
  endtask

  task automatic expect_snap(input int unsigned c, input logic [NSW-1:0] s);
    snapq.push_back('{cyc: c, sw: s, rise: '0, fall: '0});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every change of the output vector must match the next queued event.
  always @(negedge clk) begin
    exp_t e;
    logic [3*NSW-1:0] cur;
    if (mon_en) begin
      cur = {osw, orise, ofall};
      while (snapq.size() > 0 && snapq[0].cyc <= cyc) begin
        e = snapq.pop_front();
        chk("snap_cycle", cyc, e.cyc);
        chk("snap_sw",    osw,   e.sw);
        chk("snap_rise",  orise, e.rise);
        chk("snap_fall",  ofall, e.fall);
      end
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        chk("event_missing_cycle", cyc, e.cyc);
      end
      if (cur !== prev) begin
        if (evq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got sw=%b rise=%b fall=%b expected no change at cycle %0d",
                   osw, orise, ofall, cyc);
        end else begin
          e = evq.pop_front();
          chk("event_cycle", cyc,   e.cyc);
          chk("event_sw",    osw,   e.sw);
          chk("event_rise",  orise, e.rise);
          chk("event_fall",  ofall, e.fall);
        end
      end
`ifdef DEBOUNCE_EDGE_EN
      chk("rise_fall_exclusive", orise & ofall, '0);
`endif
      prev = cur;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    logic [8:0] bounce;

    // Reset state
    tick(3);
    rst = 1'b0;
    expect_snap(cyc, '0);
    prev   = '0;
    mon_en = 1'b1;
    tick(2);

    // Clean step on bit 0: 6 edges after the step edge
    k = cyc;
    sw = 4'b0001;
    expect_evt(k + 6, 4'b0001, 4'b0001, 4'b0000);
    tick(10);

    // Bounce on bit 1: 1,0,1,1,0,1,1,1,1
    bounce = 9'b111101101;
    k = cyc;
    expect_evt(k + 11, 4'b0011, 4'b0010, 4'b0000);
    for (int j = 0; j < 9; j++) begin
      sw[1] = bounce[j];
      tick(1);
    end
    tick(8);

    // Bits 2,3 rise, then all four release together
    k = cyc;
    sw = 4'b1111;
    expect_evt(k + 6, 4'b1111, 4'b1100, 4'b0000);
    tick(10);
    k = cyc;
    sw = 4'b0000;
    expect_evt(k + 6, 4'b0000, 4'b0000, 4'b1111);
    tick(10);

    // Reset after 3 of 4 counts on bit 2: latency restarts from the reset edge
    k = cyc;
    sw = 4'b0100;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    expect_snap(k + 6, 4'b0000);
    expect_evt(k + 12, 4'b0100, 4'b0100, 4'b0000);
    tick(10);

    // Reset while bit 2 is high: clears without pulses, then re-acquires
    k = cyc;
    rst = 1'b1;
    expect_evt(k + 1, 4'b0000, 4'b0000, 4'b0000);
    expect_evt(k + 7, 4'b0100, 4'b0100, 4'b0000);
    tick(1);
    rst = 1'b0;
    tick(10);

    // Low glitch of LIMIT-1 cycles on bit 2 must not toggle
    k = cyc;
    sw = 4'b0000;
    tick(3);
    sw = 4'b0100;
    expect_snap(k + 8, 4'b0100);
    tick(12);

    for (int n = 0; n < 40 && (evq.size() > 0 || snapq.size() > 0); n++) tick(1);
    tick(2);
    chk("event_queue_drained", evq.size(), 0);
    chk("snap_queue_drained", snapq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
